// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data-memory request/response bundle.
//
// Signals:
//   req_valid  pipeline -> responder  load/store present in MEM
//   MemRW      pipeline -> responder  1 = store, 0 = load
//   addr       pipeline -> responder  byte address
//   wdata      pipeline -> responder  store data
//   funct3     pipeline -> responder  access size / extension
//   stall      responder -> pipeline  freeze upstream stages
//   rvalid     responder -> pipeline  access complete this cycle
//   rdata      responder -> pipeline  extended load data (0 for stores)
//   misalign   responder -> pipeline  misaligned access flag
//
// Modports: master = pipeline side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        MemRW;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        stall;
    logic        rvalid;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output req_valid, MemRW, addr, wdata, funct3,
        input  stall, rvalid, rdata, misalign
    );

    modport slave (
        input  req_valid, MemRW, addr, wdata, funct3,
        output stall, rvalid, rdata, misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I MEM stage.
//
// Serves one load/store at a time from a DEPTH_WORDS x 32 byte-lane array.
// Each access stalls the pipeline for WAIT_STATES+1 cycles and finishes with a
// one-cycle rvalid pulse; loads come back sign/zero-extended.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  dmem_responder_if.slave (req_valid, MemRW, addr, wdata, funct3 in;
//        stall, rvalid, rdata, misalign out)
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   -> misaligned h/hu/w accesses are flagged, not written, rdata = 0
//   undefined -> misalign tied low, low address bits ignored for h/hu/w
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        misalign_q;

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Access attributes seen at the commit edge. With zero wait states the
    // commit happens on the same edge that samples the request, so the live
    // bus is used in IDLE and the latched copy otherwise.
    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [2:0]    c_funct3;
    logic [AW-1:0] c_idx;
    logic          is_byte;
    logic          is_half;
    logic          c_mis;
    logic          commit;
    logic [3:0]    be;
    logic [3:0][7:0] wlanes;
    logic [3:0][7:0] rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic          sx;
    logic [31:0]   load_ext;
    logic          unused_addr;

    always_comb begin
        if (state == StIdle) begin
            c_we     = bus.MemRW;
            c_addr   = bus.addr;
            c_wdata  = bus.wdata;
            c_funct3 = bus.funct3;
        end else begin
            c_we     = lat_we;
            c_addr   = lat_addr;
            c_wdata  = lat_wdata;
            c_funct3 = lat_funct3;
        end
    end

    assign c_idx       = c_addr[AW+1:2];
    assign unused_addr = ^c_addr[31:AW+2];

    // 011/110/111 fall through to word.
    assign is_byte = (c_funct3[1:0] == 2'b00);
    assign is_half = (c_funct3[1:0] == 2'b01);
    assign sx      = ~c_funct3[2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign c_mis = (is_half && c_addr[0]) ||
                   (!is_byte && !is_half && (c_addr[1:0] != 2'b00));
`else
    assign c_mis = 1'b0;
`endif

    // Entering DONE: either straight from IDLE (no wait states) or from the
    // last WAIT cycle. Reset wins over the commit edge.
    assign commit = !rst &&
                    (((state == StIdle) && bus.req_valid && (WAIT_STATES == 0)) ||
                     ((state == StWait) && (cnt == 4'd1)));

    always_comb begin
        if (is_byte) begin
            be     = 4'b0001 << c_addr[1:0];
            wlanes = {4{c_wdata[7:0]}};
        end else if (is_half) begin
            be     = c_addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{c_wdata[15:0]}};
        end else begin
            be     = 4'b1111;
            wlanes = c_wdata;
        end
    end

    assign rd_word = mem[c_idx];
    assign rd_byte = rd_word[c_addr[1:0]];
    assign rd_half = c_addr[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

    always_comb begin
        if (is_byte) begin
            load_ext = {{24{sx & rd_byte[7]}}, rd_byte};
        end else if (is_half) begin
            load_ext = {{16{sx & rd_half[15]}}, rd_half};
        end else begin
            load_ext = rd_word;
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[c_idx][b] <= wlanes[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        lat_we     <= bus.MemRW;
                        lat_addr   <= bus.addr;
                        lat_wdata  <= bus.wdata;
                        lat_funct3 <= bus.funct3;
                        cnt        <= 4'(WAIT_STATES);
                        state      <= (WAIT_STATES == 0) ? StDone : StWait;
                    end
                end
                StWait: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    // Request still presented this cycle; deliberately ignored.
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
            if (commit) begin
                rvalid_q   <= 1'b1;
                misalign_q <= c_mis;
                rdata_q    <= (c_we || c_mis) ? 32'd0 : load_ext;
            end
        end
    end

    assign bus.stall    = !rst && (((state == StIdle) && bus.req_valid) || (state == StWait));
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.misalign = misalign_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Three instances: [0] WAIT_STATES=1, [1] WAIT_STATES=0, [2] WAIT_STATES=3,
// all DEPTH_WORDS=1024. Honours DMEM_MISALIGN_CHECK_EN when defined.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        clk;
    logic [2:0]  rst;
    logic        req_valid [3];
    logic        memrw     [3];
    logic [31:0] addr      [3];
    logic [31:0] wdata     [3];
    logic [2:0]  funct3    [3];
    logic [2:0]  stall_o;
    logic [2:0]  rvalid_o;
    logic [2:0]  misalign_o;
    logic [31:0] rdata_o   [3];

    int checks = 0;
    int errors = 0;

    byte unsigned ref_mem [3][NBYTES];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder_if bus ();
        assign bus.req_valid = req_valid[g];
        assign bus.MemRW     = memrw[g];
        assign bus.addr      = addr[g];
        assign bus.wdata     = wdata[g];
        assign bus.funct3    = funct3[g];
        assign stall_o[g]    = bus.stall;
        assign rvalid_o[g]   = bus.rvalid;
        assign misalign_o[g] = bus.misalign;
        assign rdata_o[g]    = bus.rdata;

        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: byte-addressed memory, address taken modulo array size.
    task automatic model_access(input int k, input bit we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [31:0] rd, output bit mis);
        int unsigned sz;
        int unsigned ba;
        longint unsigned v;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ba  = a % NBYTES;
        mis = 1'b0;
        rd  = 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = (ba % sz) != 0;
`else
        ba = ba - (ba % sz);
`endif
        if (mis) return;
        if (we) begin
            for (int i = 0; i < int'(sz); i++) ref_mem[k][ba + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < int'(sz); i++) v += longint'(ref_mem[k][ba + i]) << (8 * i);
            if (sz < 4 && f3[2] == 1'b0 && v >= (64'd1 << (8 * sz - 1)))
                v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
            rd = v[31:0];
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns likewise.
    task automatic access(input int k, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rd, output bit mis);
        bit got;
        int cyc;
        got = 1'b0;
        rd  = 32'hxxxx_xxxx;
        mis = 1'b0;
        req_valid[k] = 1'b1;
        memrw[k]     = we;
        addr[k]      = a;
        wdata[k]     = wd;
        funct3[k]    = f3;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (rvalid_o[k]) begin
                got = 1'b1;
                rd  = rdata_o[k];
                mis = misalign_o[k];
                chk($sformatf("latency[%0d]", k), cyc, ws_of(k) + 1);
                chk($sformatf("stall_done[%0d]", k), stall_o[k], 1'b0);
            end else begin
                chk($sformatf("stall_hold[%0d] cyc%0d", k, cyc), stall_o[k], 1'b1);
                chk($sformatf("misalign_quiet[%0d]", k), misalign_o[k], 1'b0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        req_valid[k] = 1'b0;
        if (!got) chk($sformatf("rvalid_timeout[%0d]", k), 1'b0, 1'b1);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [13];
        logic [31:0] rd, mrd, a, wd;
        logic [2:0]  f3;
        bit          mis, mmis, we;

        tbl[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0};
        tbl[1]  = '{1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE};
        tbl[3]  = '{1'b0, 32'h13, 32'h0,        3'b100, 32'h000000DE};
        tbl[4]  = '{1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD};
        tbl[5]  = '{1'b0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF};
        tbl[6]  = '{1'b1, 32'h20, 32'h0,        3'b010, 32'h0};
        tbl[7]  = '{1'b1, 32'h21, 32'h123456AA, 3'b000, 32'h0};
        tbl[8]  = '{1'b1, 32'h22, 32'hFFFF1234, 3'b001, 32'h0};
        tbl[9]  = '{1'b0, 32'h20, 32'h0,        3'b010, 32'h1234AA00};
        tbl[10] = '{1'b0, 32'h20, 32'h0,        3'b011, 32'h1234AA00};
        tbl[11] = '{1'b0, 32'h21, 32'h0,        3'b000, 32'hFFFFFFAA};
        tbl[12] = '{1'b0, 32'h22, 32'h0,        3'b101, 32'h00001234};

        rst = 3'b111;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            memrw[k]     = 1'b0;
            addr[k]      = 32'd0;
            wdata[k]     = 32'd0;
            funct3[k]    = 3'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Request during reset must not raise stall.
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("stall_in_rst[%0d]", k), stall_o[k], 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
        rst = 3'b000;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_stall[%0d]", k), stall_o[k], 1'b0);
            chk($sformatf("rst_rvalid[%0d]", k), rvalid_o[k], 1'b0);
            chk($sformatf("rst_rdata[%0d]", k), rdata_o[k], 32'h0);
            chk($sformatf("rst_misalign[%0d]", k), misalign_o[k], 1'b0);
        end
        @(posedge clk);
        #1;

        // Table-driven round-trip / extension / lane merge on WAIT_STATES=1.
        for (int i = 0; i < 13; i++) begin
            access(0, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].f3, rd, mis);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
            chk($sformatf("tbl%0d_misalign", i), mis, 1'b0);
        end
        // rdata holds after DONE.
        @(negedge clk);
        chk("rdata_hold", rdata_o[0], 32'h00001234);
        chk("rvalid_pulse", rvalid_o[0], 1'b0);
        @(posedge clk);
        #1;

        // Misalignment on WAIT_STATES=1.
        access(0, 1'b1, 32'h40, 32'h11111111, 3'b010, rd, mis);
        access(0, 1'b1, 32'h42, 32'h00000099, 3'b010, rd, mis);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis_flag", mis, 1'b1);
        chk("mis_rdata", rd, 32'h0);
        access(0, 1'b0, 32'h40, 32'h0, 3'b010, rd, mis);
        chk("mis_unchanged", rd, 32'h11111111);
`else
        chk("mis_flag", mis, 1'b0);
        access(0, 1'b0, 32'h40, 32'h0, 3'b010, rd, mis);
        chk("mis_aligned_write", rd, 32'h00000099);
`endif
        chk("mis_load_flag", mis, 1'b0);

        // Zero wait states and address wrap.
        access(1, 1'b1, 32'h1000, 32'h55, 3'b010, rd, mis);
        access(1, 1'b0, 32'h0, 32'h0, 3'b010, rd, mis);
        chk("wrap_rdata", rd, 32'h55);

        // Reset mid-access on WAIT_STATES=3.
        access(2, 1'b1, 32'h40, 32'h11223344, 3'b010, rd, mis);
        req_valid[2] = 1'b1;
        memrw[2]     = 1'b1;
        addr[2]      = 32'h40;
        wdata[2]     = 32'h77;
        funct3[2]    = 3'b010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("abort_stall_c%0d", c), stall_o[2], 1'b1);
            @(posedge clk);
            #1;
        end
        rst[2] = 1'b1;
        @(negedge clk);
        chk("abort_stall_in_rst", stall_o[2], 1'b0);
        chk("abort_rvalid_in_rst", rvalid_o[2], 1'b0);
        @(posedge clk);
        #1;
        rst[2]       = 1'b0;
        req_valid[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("abort_no_rvalid_c%0d", c), rvalid_o[2], 1'b0);
            chk($sformatf("abort_stall_low_c%0d", c), stall_o[2], 1'b0);
        end
        @(posedge clk);
        #1;
        access(2, 1'b0, 32'h40, 32'h0, 3'b010, rd, mis);
        chk("abort_old_contents", rd, 32'h11223344);

        // Randomized traffic against the model on a region disjoint from above.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++) begin
                a  = 32'h100 + 32'(4 * w);
                wd = $urandom;
                access(k, 1'b1, a, wd, 3'b010, rd, mis);
                model_access(k, 1'b1, a, wd, 3'b010, mrd, mmis);
                chk($sformatf("fill[%0d]_rdata", k), rd, mrd);
            end
            for (int n = 0; n < 120; n++) begin
                we = 1'($urandom % 2);
                f3 = we ? 3'($urandom % 3) : 3'($urandom % 8);
                a  = 32'h100 + 32'($urandom % 64) + 32'(($urandom % 4) * NBYTES);
                wd = $urandom;
                access(k, we, a, wd, f3, rd, mis);
                model_access(k, we, a, wd, f3, mrd, mmis);
                chk($sformatf("rand[%0d] n%0d we%0d f3=%0d a=%h rdata", k, n, we, f3, a), rd, mrd);
                chk($sformatf("rand[%0d] n%0d misalign", k, n), mis, mmis);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I 5-stage pipeline. It serves the load/store requests that decode marks with MemRW and WBSel = Mem, as they arrive from the MEM stage. It holds the pipeline with `stall` for a configurable number of wait states. It completes each access with a one-cycle `rvalid` pulse, and returns loads already sign- or zero-extended for the writeback mux.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two ≥ 4.
- `WAIT_STATES`, 1: extra cycles inserted per access; range 0–15.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset. Synchronous, active-high.
- `req_valid`, in, 1: MEM stage holds a load or store. Held stable by the pipeline while `stall` = 1.
- `MemRW`, in, 1: 1 = store, 0 = load.
- `addr`, in, 32: byte address (ALU result).
- `wdata`, in, 32: store data (rs2).
- `funct3`, in, 3: access size. 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
- `stall`, out, 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `rvalid`, out, 1: access complete; `rdata` is valid this cycle.
- `rdata`, out, 32: extended load data; 0 for stores.
- `misalign`, out, 1: misaligned access flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - `stall` = `req_valid` (combinational).
  - On `req_valid` = 1, latch `MemRW`, `addr`, `wdata` and `funct3`, and load `cnt` = `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES` > 0, otherwise DONE.
- **WAIT**
  - `stall` = 1.
  - `cnt` decrements each cycle; when `cnt` = 1, next state is DONE.
- **DONE**
  - `stall` = 0, `rvalid` = 1.
  - `req_valid` is ignored, because the pipeline still presents the same request this cycle.
  - Next state is always IDLE.
- **Commit point:** the array is written, and load data is registered into `rdata`, on the edge that enters DONE. Every access is single-commit.
- **Word index:** `addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- **Stores** use byte-lane write enables:
  - sb writes lane `addr[1:0]` with `wdata[7:0]`.
  - sh writes lanes {`addr[1]`, 0..1} with `wdata[15:0]`.
  - sw writes all four lanes.
- **Loads:**
  - lb and lh sign-extend bit 7 and bit 15 respectively.
  - lbu and lhu zero-extend.
  - lw returns the word unchanged.
- `funct3` values 011, 110 and 111 are treated as w.
- `rdata` holds its value outside DONE.
- A store to a word in DONE followed by a load of that word is seen by the load: the new load samples in IDLE and reads the array after commit.

## Timing
- Request sampled in IDLE at cycle 0 → `rvalid` at cycle `WAIT_STATES`+1.
- `stall` is high on cycles 0 .. `WAIT_STATES`.
- Throughput: one access every `WAIT_STATES`+2 cycles; the IDLE cycle is required between accesses.
- Reset values:
  - state = IDLE
  - `cnt` = 0
  - `stall` = 0
  - `rvalid` = 0
  - `rdata` = 0
  - `misalign` = 0
- Array contents are not reset.
- `rst` asserted mid-access (in WAIT or IDLE with a request) aborts the access: no write and no `rvalid`. State goes to IDLE on the next edge.
- `rst` takes priority over every transition, including the commit edge.
- `stall` is forced to 0 while `rst` = 1.

## Configuration
- Macro: `DMEM_MISALIGN_CHECK_EN`.
- **Defined:**
  - A misaligned access (h/hu with `addr[0]` = 1, or w with `addr[1:0]` ≠ 0) is flagged by `misalign` = 1, asserted with `rvalid` in DONE.
  - No array write occurs and `rdata` = 0.
  - Latency is unchanged.
- **Undefined:**
  - `misalign` is tied to 0.
  - For w the low address bits `addr[1:0]` are ignored; for h/hu `addr[0]` is ignored.
  - The access proceeds as aligned.

## Test plan
- **Word round-trip.** `WAIT_STATES` = 1. sw 0xDEADBEEF at 0x10, then lw at 0x10.
  - Each access: `stall` high 2 cycles, `rvalid` at cycle 2.
  - Load returns `rdata` = 0xDEADBEEF.
- **Byte/half extension.** After the word above:
  - lb at 0x13 → 0xFFFFFFDE
  - lbu at 0x13 → 0x000000DE
  - lh at 0x12 → 0xFFFFDEAD
  - lhu at 0x10 → 0x0000BEEF
- **Lane merge.** sw 0 at 0x20, then sb 0xAA at 0x21, then sh 0x1234 at 0x22. lw at 0x20 → 0x1234AA00.
- **Zero wait states and wrap.** `WAIT_STATES` = 0, `DEPTH_WORDS` = 1024.
  - sw 0x55 at 0x1000. `rvalid` at cycle 1, `stall` high 1 cycle.
  - lw at 0x0 → 0x55 (address wraps).
- **Reset mid-access.** `WAIT_STATES` = 3. sw 0x77 at 0x40, assert `rst` in the second WAIT cycle.
  - No `rvalid`; `stall` = 0 next cycle.
  - Subsequent lw at 0x40 returns the old contents.
- **Misalignment.**
  - With `DMEM_MISALIGN_CHECK_EN` defined: sw at 0x42 → `misalign` = 1 with `rvalid`, and the word at 0x40 is unchanged.
  - Without the macro: sw 0x99 at 0x42 writes the word at 0x40; lw at 0x40 → 0x99.
